// File: rtl/cpu_pc_pkg.sv
// Shared types and constants for the fetch PC / next-PC logic.
// Used by cpu_next_pc_unit and cpu_branch_target_calc.
package cpu_pc_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] PC_STEP              = 32'd4;
   localparam logic [XLEN-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
   localparam logic [XLEN-1:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      REDIRECT = 2'd1,
      TRAP     = 2'd2
   } pc_state_e;

   // Instructions are 4-byte aligned; bit 0 of a jalr target is always cleared.
   function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
      return addr[1];
   endfunction

endpackage

// File: rtl/cpu_branch_target_calc.sv
// Combinational control-flow resolution: taken decision, target address and
// misalignment flag for branch / jal / jalr (jalr has highest priority).
module cpu_branch_target_calc
   import cpu_pc_pkg::*;
(
   input  logic            ex_is_branch,
   input  logic            ex_is_jal,
   input  logic            ex_is_jalr,
   input  logic [XLEN-1:0] ex_pc,
   input  logic [XLEN-1:0] ex_imm,
   input  logic [XLEN-1:0] ex_rs1,
   input  logic            condition_satisfied,
   output logic            taken,
   output logic [XLEN-1:0] target,
   output logic            misaligned
);

   logic [XLEN-1:0] pc_rel_s;
   logic [XLEN-1:0] jalr_sum_s;

   assign pc_rel_s   = ex_pc + ex_imm;
   assign jalr_sum_s = ex_rs1 + ex_imm;

   // Resolve the taken decision and target with jalr > jal > branch priority.
   always_comb begin
      taken  = 1'b0;
      target = pc_rel_s;
      if (ex_is_jalr) begin
         taken  = 1'b1;
         target = jalr_sum_s & 32'hFFFF_FFFE;
      end else if (ex_is_jal) begin
         taken  = 1'b1;
         target = pc_rel_s;
      end else if (ex_is_branch) begin
         taken  = condition_satisfied;
         target = pc_rel_s;
      end else begin
         taken  = 1'b0;
         target = pc_rel_s;
      end
   end

   assign misaligned = taken & is_misaligned(target);

endmodule

// File: rtl/cpu_next_pc_unit.sv
// Architectural fetch PC register and redirect/trap sequencer sitting between
// the EX stage resolution and the fetch request port.
module cpu_next_pc_unit
   import cpu_pc_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
   parameter logic [31:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ex_valid,
   output logic        ex_ready,
   input  logic        ex_is_branch,
   input  logic        ex_is_jal,
   input  logic        ex_is_jalr,
   input  logic [31:0] ex_pc,
   input  logic [31:0] ex_imm,
   input  logic [31:0] ex_rs1,
   input  logic        condition_satisfied,
   output logic [31:0] link_addr,
   output logic        fetch_valid,
   input  logic        fetch_ready,
   output logic [31:0] fetch_pc,
   output logic        flush,
   output logic        misaligned_trap,
   output logic [31:0] trap_addr,
   input  logic        trap_ack
);

   pc_state_e   state_r;
   pc_state_e   next_state_s;
   logic [31:0] pc_r;
   logic [31:0] pc_next_s;
   logic [31:0] trap_addr_r;
   logic [31:0] trap_addr_next_s;
   logic        fetch_valid_r;
   logic        ex_ready_r;
   logic        flush_r;
   logic        misaligned_trap_r;
   logic        fetch_valid_next_s;
   logic        ex_ready_next_s;
   logic        flush_next_s;
   logic        misaligned_trap_next_s;
   logic        taken_s;
   logic [31:0] target_s;
   logic        misaligned_s;
   logic        ex_fire_s;
   logic        fetch_fire_s;

   cpu_branch_target_calc u_target_calc (
      .ex_is_branch        (ex_is_branch),
      .ex_is_jal           (ex_is_jal),
      .ex_is_jalr          (ex_is_jalr),
      .ex_pc               (ex_pc),
      .ex_imm              (ex_imm),
      .ex_rs1              (ex_rs1),
      .condition_satisfied (condition_satisfied),
      .taken               (taken_s),
      .target              (target_s),
      .misaligned          (misaligned_s)
   );

   // Handshake qualifiers come only from registered readiness/valid flags.
   assign ex_fire_s    = ex_valid & ex_ready_r;
   assign fetch_fire_s = fetch_valid_r & fetch_ready;
   assign link_addr    = ex_pc + PC_STEP;

   // Next-state and next-PC selection; a taken redirect overrides a same-cycle fetch step.
   always_comb begin
      next_state_s     = state_r;
      pc_next_s        = pc_r;
      trap_addr_next_s = trap_addr_r;
      case (state_r)
         RUN: begin
            if (ex_fire_s && taken_s) begin
               if (misaligned_s) begin
                  next_state_s     = TRAP;
                  trap_addr_next_s = target_s;
               end else begin
                  next_state_s = REDIRECT;
                  pc_next_s    = target_s;
               end
            end else if (fetch_fire_s) begin
               pc_next_s = pc_r + PC_STEP;
            end else begin
               pc_next_s = pc_r;
            end
         end
         REDIRECT: begin
            next_state_s = RUN;
         end
         TRAP: begin
            if (trap_ack) begin
               next_state_s = RUN;
               pc_next_s    = TRAP_VECTOR;
            end else begin
               next_state_s = TRAP;
            end
         end
         default: begin
            next_state_s = RUN;
            pc_next_s    = RESET_VECTOR;
         end
      endcase
   end

   // Output flags are pre-decoded from the next state so they leave the unit registered.
   always_comb begin
      fetch_valid_next_s     = (next_state_s == RUN);
      ex_ready_next_s        = (next_state_s == RUN);
      misaligned_trap_next_s = (next_state_s == TRAP);
      flush_next_s           = (next_state_s == REDIRECT) ||
                               ((next_state_s == TRAP) && (state_r != TRAP));
   end

   // State, PC and registered output flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r           <= RUN;
         pc_r              <= RESET_VECTOR;
         trap_addr_r       <= 32'h0000_0000;
         fetch_valid_r     <= 1'b0;
         ex_ready_r        <= 1'b0;
         flush_r           <= 1'b0;
         misaligned_trap_r <= 1'b0;
      end else begin
         state_r           <= next_state_s;
         pc_r              <= pc_next_s;
         trap_addr_r       <= trap_addr_next_s;
         fetch_valid_r     <= fetch_valid_next_s;
         ex_ready_r        <= ex_ready_next_s;
         flush_r           <= flush_next_s;
         misaligned_trap_r <= misaligned_trap_next_s;
      end
   end

   assign fetch_pc        = pc_r;
   assign trap_addr       = trap_addr_r;
   assign fetch_valid     = fetch_valid_r;
   assign ex_ready        = ex_ready_r;
   assign flush           = flush_r;
   assign misaligned_trap = misaligned_trap_r;

endmodule

// File: tb/tb_cpu_next_pc_unit.sv
// Self-checking bench for cpu_next_pc_unit: directed scenarios followed by
// randomized traffic, compared cycle by cycle against a behavioural model.
module tb_cpu_next_pc_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid;
   logic        ex_ready;
   logic        ex_is_branch;
   logic        ex_is_jal;
   logic        ex_is_jalr;
   logic [31:0] ex_pc;
   logic [31:0] ex_imm;
   logic [31:0] ex_rs1;
   logic        condition_satisfied;
   logic [31:0] link_addr;
   logic        fetch_valid;
   logic        fetch_ready;
   logic [31:0] fetch_pc;
   logic        flush;
   logic        misaligned_trap;
   logic [31:0] trap_addr;
   logic        trap_ack;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: mode 0 = fetching, 1 = one-cycle bubble, 2 = waiting for trap ack.
   logic [31:0] m_pc;
   logic [31:0] m_trap_addr;
   int          m_mode;
   bit          m_first;
   bit          m_live;

   always #5 clk = ~clk;

   cpu_next_pc_unit dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .ex_valid            (ex_valid),
      .ex_ready            (ex_ready),
      .ex_is_branch        (ex_is_branch),
      .ex_is_jal           (ex_is_jal),
      .ex_is_jalr          (ex_is_jalr),
      .ex_pc               (ex_pc),
      .ex_imm              (ex_imm),
      .ex_rs1              (ex_rs1),
      .condition_satisfied (condition_satisfied),
      .link_addr           (link_addr),
      .fetch_valid         (fetch_valid),
      .fetch_ready         (fetch_ready),
      .fetch_pc            (fetch_pc),
      .flush               (flush),
      .misaligned_trap     (misaligned_trap),
      .trap_addr           (trap_addr),
      .trap_ack            (trap_ack)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %08h expected %08h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_outputs();
      bit running;
      running = m_live && (m_mode == 0);
      check_eq("fetch_valid", {31'd0, fetch_valid}, {31'd0, running});
      check_eq("ex_ready", {31'd0, ex_ready}, {31'd0, running});
      check_eq("flush", {31'd0, flush}, {31'd0, (m_mode == 1) || (m_mode == 2 && m_first)});
      check_eq("misaligned_trap", {31'd0, misaligned_trap}, {31'd0, m_mode == 2});
      check_eq("fetch_pc", fetch_pc, m_pc);
      check_eq("trap_addr", trap_addr, m_trap_addr);
   endtask

   // Called at a falling edge: apply inputs, advance the model over the next rising edge, check.
   task automatic drive(input bit v, input bit br, input bit jal, input bit jalr, input bit cond,
                        input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] rs1,
                        input bit fr, input bit ack);
      bit          tk;
      logic [31:0] tgt;
      ex_valid = v; ex_is_branch = br; ex_is_jal = jal; ex_is_jalr = jalr;
      condition_satisfied = cond; ex_pc = pc; ex_imm = imm; ex_rs1 = rs1;
      fetch_ready = fr; trap_ack = ack;
      #1;
      check_eq("link_addr", link_addr, pc + 32'd4);
      tk = jalr || jal || (br && cond);
      if (jalr) begin
         tgt = rs1 + imm;
         tgt = tgt - (tgt % 32'd2);
      end else begin
         tgt = pc + imm;
      end
      if (!m_live) begin
         m_live = 1'b1;
      end else if (m_mode == 0) begin
         if (v && tk) begin
            if ((tgt % 32'd4) >= 32'd2) begin
               m_mode = 2; m_first = 1'b1; m_trap_addr = tgt;
            end else begin
               m_mode = 1; m_pc = tgt;
            end
         end else if (fr) begin
            m_pc = m_pc + 32'd4;
         end
      end else if (m_mode == 1) begin
         m_mode = 0;
      end else begin
         m_first = 1'b0;
         if (ack) begin
            m_mode = 0; m_pc = 32'h0000_0100;
         end
      end
      @(negedge clk);
      check_outputs();
   endtask

   task automatic idle(input bit fr);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, fr, 1'b0);
   endtask

   // Asynchronous reset asserted mid-cycle, checked immediately, released on a falling edge.
   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      #1;
      m_pc = 32'h0; m_trap_addr = 32'h0; m_mode = 0; m_first = 1'b0; m_live = 1'b0;
      check_outputs();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      ex_valid = 1'b0; ex_is_branch = 1'b0; ex_is_jal = 1'b0; ex_is_jalr = 1'b0;
      condition_satisfied = 1'b0; ex_pc = 32'h0; ex_imm = 32'h0; ex_rs1 = 32'h0;
      fetch_ready = 1'b0; trap_ack = 1'b0;
      @(negedge clk);
      do_reset();

      // Reset release then sequential fetch 0,4,8,C.
      for (int i = 0; i < 5; i++) idle(1'b1);
      check_eq("seq_pc_10", fetch_pc, 32'h0000_0010);

      // BEQ taken with a concurrent fetch transfer.
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h20, 32'h40, 32'h0, 1'b1, 1'b0);
      check_eq("beq_flush", {31'd0, flush}, 32'd1);
      idle(1'b1);
      check_eq("beq_target", fetch_pc, 32'h0000_0060);

      // BNE not taken.
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h20, 32'h40, 32'h0, 1'b1, 1'b0);
      check_eq("bne_seq", fetch_pc, 32'h0000_0064);

      // JALR to a misaligned target, acknowledged three cycles later.
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h80, 32'h2, 32'h1001, 1'b1, 1'b0);
      check_eq("jalr_trap_addr", trap_addr, 32'h0000_1002);
      idle(1'b1);
      idle(1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
      check_eq("trap_vector", fetch_pc, 32'h0000_0100);

      // JAL whose target wraps to zero, then a PC wrap on sequential fetch.
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h10, 32'h0, 1'b1, 1'b0);
      idle(1'b1);
      check_eq("jal_wrap", fetch_pc, 32'h0000_0000);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0);
      idle(1'b0);
      idle(1'b1);
      check_eq("pc_wrap", fetch_pc, 32'h0000_0000);

      // EX resolution held through REDIRECT is accepted on the next RUN cycle.
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h200, 32'h0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h300, 32'h100, 32'h0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h300, 32'h100, 32'h0, 1'b0, 1'b0);
      check_eq("held_accept", fetch_pc, 32'h0000_0400);

      // Reset pulse while a trap is pending.
      idle(1'b0);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h12, 32'h0, 1'b0, 1'b0);
      idle(1'b0);
      do_reset();
      idle(1'b1);
      check_eq("reset_from_trap", fetch_pc, 32'h0000_0000);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            do_reset();
         end else begin
            drive($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 1) == 1,
                  $urandom & 32'hFFFF_FFFC, ($urandom & 32'h0000_0FFF) - 32'h0000_0800,
                  $urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cpu_next_pc_unit.md
Name: cpu_next_pc_unit

Overview:
- Owns the architectural fetch PC register.
- Consumes control-flow resolutions from the EX stage, including condition_satisfied from cpu_branch_tester, and decides whether fetch continues sequentially or redirects.
- On a redirect it squashes younger instructions with a flush pulse. It raises a held trap on a misaligned target and waits for the trap controller to acknowledge.
- Sits between EX (upstream) and the fetch/IMEM request port (downstream).

Parameters:
RESET_VECTOR, 32'h0000_0000, PC loaded on reset
TRAP_VECTOR, 32'h0000_0100, PC loaded on trap_ack

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
ex_valid  in  1  EX presents a resolved instruction
ex_ready  out  1  unit accepts the EX resolution this cycle
ex_is_branch  in  1  conditional branch
ex_is_jal  in  1  JAL
ex_is_jalr  in  1  JALR
ex_pc  in  32  PC of the EX instruction
ex_imm  in  32  sign-extended immediate
ex_rs1  in  32  rs1 value (JALR base)
condition_satisfied  in  1  from cpu_branch_tester
link_addr  out  32  ex_pc+4, combinational
fetch_valid  out  1  fetch_pc is a valid request
fetch_ready  in  1  fetch accepts the request
fetch_pc  out  32  current PC
flush  out  1  squash all younger in-flight instructions
misaligned_trap  out  1  instruction-address-misaligned pending
trap_addr  out  32  offending target address
trap_ack  in  1  trap controller has taken the trap

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_VECTOR, state=RUN.
  - fetch_valid=0, flush=0, misaligned_trap=0, trap_addr=0.
- First cycle after rst_n rises: fetch_valid=1, fetch_pc=RESET_VECTOR.
- States: RUN, REDIRECT, TRAP (enum in the package).
- Handshakes:
  - Fetch: a transfer occurs when fetch_valid & fetch_ready.
  - EX: accepted when ex_valid & ex_ready.
  - ex_ready=1 only in RUN.
- RUN outputs: fetch_valid=1, fetch_pc=pc. On a fetch transfer, pc<=pc+4, wrapping mod 2^32 (FFFF_FFFC -> 0000_0000).
- Resolution, on an accepted EX transfer:
  - Priority jalr > jal > branch if several flags are set.
  - taken = is_jalr | is_jal | (is_branch & condition_satisfied).
  - Target for branch/jal: ex_pc+ex_imm. Target for jalr: (ex_rs1+ex_imm) & ~32'h1. All arithmetic is 32-bit with wrap.
  - misaligned = taken & target[1].
  - A resolution with no flags set, or not taken, has no effect beyond the handshake.
- Taken and aligned:
  - pc<=target at the edge; next state REDIRECT.
  - Overrides any same-cycle fetch transfer: pc+4 is discarded, and that fetched instruction is squashed by the following flush.
- REDIRECT (exactly 1 cycle):
  - flush=1, fetch_valid=0, ex_ready=0.
  - Then RUN with fetch_pc=target.
  - Redirect penalty: 1 bubble cycle in addition to the squashed stages.
- Taken and misaligned:
  - pc unchanged; trap_addr<=target; next state TRAP.
- TRAP:
  - misaligned_trap=1 held. flush=1 in the first TRAP cycle only, 0 afterwards.
  - fetch_valid=0, ex_ready=0.
  - On trap_ack: pc<=TRAP_VECTOR, misaligned_trap<=0, next state RUN.
  - trap_ack outside TRAP is ignored.
- flush, misaligned_trap, fetch_valid and ex_ready are decoded from registered state only; none depends combinationally on ex_* or fetch_ready.
- ex_valid deasserted, or ex_valid while ex_ready=0: no state change. Upstream holds its data.
- rst_n asserted in any state returns immediately to the reset values, aborting a pending REDIRECT or TRAP.

Decomposition:
- Package cpu_pc_pkg holds:
  - state enum {RUN, REDIRECT, TRAP}
  - PC_STEP=4
  - default vector constants
  - XLEN=32
- Sub-module cpu_branch_target_calc (combinational): inputs are the flags, ex_pc, ex_imm, ex_rs1 and condition_satisfied; outputs are taken, target and misaligned.
- FSM and PC register live in the top module.

Test Plan:
- Reset release with RESET_VECTOR=0, fetch_ready=1 for 4 cycles -> fetch_pc 0,4,8,C; flush=0 throughout.
- BEQ: ex_pc=0x20, imm=0x40, condition_satisfied=1, while a fetch transfers -> next cycle flush=1, fetch_valid=0; following cycle fetch_pc=0x60, not 0x24.
- BNE not taken: ex_pc=0x20, imm=0x40, condition_satisfied=0 -> no flush; pc continues +4.
- JALR: rs1=0x1001, imm=0x2 -> target 0x1002, misaligned_trap=1, trap_addr=0x1002, flush for one cycle only. trap_ack 3 cycles later -> fetch_pc=0x100, trap clears.
- JAL: ex_pc=0xFFFF_FFF0, imm=0x10 -> target wraps to 0x0000_0000, link_addr=0xFFFF_FFF4. PC wrap check: pc=0xFFFF_FFFC with a fetch transfer -> fetch_pc=0x0.
- rst_n pulsed low during TRAP -> misaligned_trap=0 immediately, fetch_pc=RESET_VECTOR after release; ex_valid held during REDIRECT -> ex_ready=0 and the resolution is accepted the next RUN cycle.
